// File: rtl/gate_seq_pkg.sv
// ============================================================================
// Module  : gate_seq_pkg
// Brief   : Shared constants and state encoding for the gate-cell self-test.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_seq_pkg;

   localparam int unsigned c_NUM_VECTORS = 8;
   localparam int unsigned c_IDX_W       = 3;
   localparam int unsigned c_TIMER_W     = 4;

   localparam logic [c_NUM_VECTORS-1:0] c_EXPECTED_TT_DEFAULT = 8'h14;

   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_DRIVE  = 3'd1;
   localparam logic [2:0] c_ST_SETTLE = 3'd2;
   localparam logic [2:0] c_ST_SAMPLE = 3'd3;
   localparam logic [2:0] c_ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = c_ST_IDLE,
      ST_DRIVE  = c_ST_DRIVE,
      ST_SETTLE = c_ST_SETTLE,
      ST_SAMPLE = c_ST_SAMPLE,
      ST_DONE   = c_ST_DONE
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/cell_settle_timer.sv
// ============================================================================
// Module  : cell_settle_timer
// Brief   : Loadable down-counter with zero flag, paces the settle window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cell_settle_timer
   import gate_seq_pkg::*;
#(
   parameter int unsigned WIDTH = c_TIMER_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   // Counting stops at zero so a late enable can never wrap the window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/gate_cell_sequencer.sv
// ============================================================================
// Module  : gate_cell_sequencer
// Brief   : Steps a 3-input gate cell through all vectors and grades its output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_cell_sequencer
   import gate_seq_pkg::*;
#(
   parameter int unsigned                SETTLE_CYCLES = 2,
   parameter logic [c_NUM_VECTORS-1:0]   EXPECTED_TT   = c_EXPECTED_TT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     cell_y,
   output logic                     cell_a,
   output logic                     cell_b,
   output logic                     cell_c,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [c_NUM_VECTORS-1:0] result,
   output logic [3:0]               err_count,
   output logic                     fail_valid,
   output logic [c_IDX_W-1:0]       first_fail_idx
);

   // The timer is loaded with N-1 so SETTLE lasts exactly N cycles.
   localparam bit                   c_SKIP_SETTLE = (SETTLE_CYCLES == 0);
   localparam logic [c_TIMER_W-1:0] c_SETTLE_LOAD =
      c_SKIP_SETTLE ? '0 : c_TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [c_IDX_W-1:0]   c_LAST_IDX    = c_IDX_W'(c_NUM_VECTORS - 1);

   seq_state_t r_state;
   seq_state_t w_state_next;

   logic                     w_launch;
   logic                     w_abort_run;
   logic                     w_sample;
   logic                     w_timer_load;
   logic                     w_timer_en;
   logic                     w_timer_zero;
   logic                     w_mismatch;
   logic [3:0]               w_err_next;

   logic [2:0]               r_cell_abc;
   logic [c_IDX_W-1:0]       r_idx;
   logic [c_NUM_VECTORS-1:0] r_result;
   logic [3:0]               r_err_count;
   logic                     r_fail_valid;
   logic [c_IDX_W-1:0]       r_first_fail_idx;
   logic                     r_pass;

   cell_settle_timer #(
      .WIDTH      (c_TIMER_W)
   ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_timer_load),
      .i_load_val (c_SETTLE_LOAD),
      .i_en       (w_timer_en),
      .o_zero     (w_timer_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_launch     = 1'b0;
      w_abort_run  = 1'b0;
      w_sample     = 1'b0;
      w_timer_load = 1'b0;
      w_timer_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_launch     = 1'b1;
               w_state_next = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (abort) begin
               w_abort_run  = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_timer_load = 1'b1;
               w_state_next = c_SKIP_SETTLE ? ST_SAMPLE : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               w_abort_run  = 1'b1;
               w_state_next = ST_IDLE;
            end else if (w_timer_zero) begin
               w_state_next = ST_SAMPLE;
            end else begin
               w_timer_en   = 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               w_abort_run  = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               w_sample     = 1'b1;
               w_state_next = (r_idx == c_LAST_IDX) ? ST_DONE : ST_DRIVE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_mismatch = (cell_y != EXPECTED_TT[r_idx]);
   assign w_err_next = r_err_count + {3'b000, w_mismatch};

   // pass folds in a mismatch on the last vector, so it is valid alongside done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cell_abc       <= '0;
         r_idx            <= '0;
         r_result         <= '0;
         r_err_count      <= '0;
         r_fail_valid     <= 1'b0;
         r_first_fail_idx <= '0;
         r_pass           <= 1'b0;
      end else if (w_launch) begin
         r_cell_abc       <= '0;
         r_idx            <= '0;
         r_result         <= '0;
         r_err_count      <= '0;
         r_fail_valid     <= 1'b0;
         r_first_fail_idx <= '0;
         r_pass           <= 1'b0;
      end else if (w_abort_run) begin
         r_cell_abc       <= '0;
      end else if (w_sample) begin
         r_result[r_idx]  <= cell_y;
         r_err_count      <= w_err_next;
         if (w_mismatch && !r_fail_valid) begin
            r_fail_valid     <= 1'b1;
            r_first_fail_idx <= r_idx;
         end
         if (r_idx == c_LAST_IDX) begin
            r_pass <= (w_err_next == 4'd0);
         end else begin
            r_idx      <= r_idx + 1'b1;
            r_cell_abc <= r_idx + 1'b1;
         end
      end
   end

   assign {cell_a, cell_b, cell_c} = r_cell_abc;
   assign busy           = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) ||
                           (r_state == ST_SAMPLE);
   assign done           = (r_state == ST_DONE);
   assign pass           = r_pass;
   assign result         = r_result;
   assign err_count      = r_err_count;
   assign fail_valid     = r_fail_valid;
   assign first_fail_idx = r_first_fail_idx;

endmodule

`default_nettype wire

// File: tb/tb_gate_cell_sequencer.sv
// ============================================================================
// Module  : tb_gate_cell_sequencer
// Brief   : Directed bench with a cycle-count model of the gate-cell self-test.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gate_cell_sequencer;

   localparam int S   = 2;
   localparam int P   = S + 2;
   localparam int RUN = 8 * P;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [1:0] fault = 2'd0;
   logic cell_y, cell_a, cell_b, cell_c, busy, done, pass, fail_valid;
   logic [7:0] result;
   logic [3:0] err_count;
   logic [2:0] first_fail_idx;

   logic rst_nz = 1'b0;
   logic start_z = 1'b0;
   logic cell_y_z, a_z, b_z, c_z, busy_z, done_z, pass_z, fv_z;
   logic [7:0] result_z;
   logic [3:0] err_z;
   logic [2:0] ff_z;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   logic [7:0] tt_v = 8'h14;

   int m_t = 0;
   logic [7:0] m_result = '0;
   logic [3:0] m_err = '0;
   logic m_fv = 1'b0;
   logic [2:0] m_ff = '0;
   logic m_pass = 1'b0;
   logic [2:0] m_abc = '0;

   always #5 clk = ~clk;

   // fault: 0 = healthy cell, 1 = stuck-at-0, 2 = stuck-at-1
   function automatic logic cell_fn(input logic [1:0] f, input logic [2:0] v);
      logic a, b, c;
      {a, b, c} = v;
      case (f)
         2'd1:    return 1'b0;
         2'd2:    return 1'b1;
         default: return ~((~(a ^ b)) | ((a & b) ^ c));
      endcase
   endfunction

   assign cell_y   = cell_fn(fault, {cell_a, cell_b, cell_c});
   assign cell_y_z = cell_fn(2'd0, {a_z, b_z, c_z});

   gate_cell_sequencer #(.SETTLE_CYCLES(S), .EXPECTED_TT(8'h14)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cell_y(cell_y),
      .cell_a(cell_a), .cell_b(cell_b), .cell_c(cell_c), .busy(busy), .done(done),
      .pass(pass), .result(result), .err_count(err_count), .fail_valid(fail_valid),
      .first_fail_idx(first_fail_idx)
   );

   gate_cell_sequencer #(.SETTLE_CYCLES(0), .EXPECTED_TT(8'h14)) dut_z (
      .clk(clk), .rst_n(rst_nz), .start(start_z), .abort(1'b0), .cell_y(cell_y_z),
      .cell_a(a_z), .cell_b(b_z), .cell_c(c_z), .busy(busy_z), .done(done_z),
      .pass(pass_z), .result(result_z), .err_count(err_z), .fail_valid(fv_z),
      .first_fail_idx(ff_z)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // m_t: 0 idle, 1..RUN busy (vector k, phase within its P-cycle slot), RUN+1 done
   always @(posedge clk) begin : model
      int k, ph;
      logic y;
      logic [3:0] e;
      if (!rst_n) begin
         m_t <= 0; m_result <= '0; m_err <= '0; m_fv <= 1'b0;
         m_ff <= '0; m_pass <= 1'b0; m_abc <= '0;
      end else if (m_t == 0) begin
         if (start && !abort) begin
            m_t <= 1; m_result <= '0; m_err <= '0; m_fv <= 1'b0;
            m_ff <= '0; m_pass <= 1'b0; m_abc <= '0;
         end
      end else if (m_t == RUN + 1) begin
         m_t <= 0;
      end else if (abort) begin
         m_t <= 0;
         m_abc <= '0;
      end else begin
         k  = (m_t - 1) / P;
         ph = (m_t - 1) % P;
         if (ph == P - 1) begin
            y = cell_fn(fault, 3'(k));
            e = m_err;
            m_result[k] <= y;
            if (y != tt_v[k]) begin
               e = e + 4'd1;
               if (!m_fv) begin
                  m_fv <= 1'b1;
                  m_ff <= 3'(k);
               end
            end
            m_err <= e;
            if (k == 7) m_pass <= (e == 4'd0);
            else        m_abc  <= 3'(k + 1);
         end
         m_t <= m_t + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("per_cycle",
               {10'd0, busy, done, cell_a, cell_b, cell_c, result, err_count,
                fail_valid, first_fail_idx, pass},
               {10'd0, (m_t >= 1 && m_t <= RUN), (m_t == RUN + 1), m_abc, m_result,
                m_err, m_fv, m_ff, m_pass});
      end
   end

   // Drives one run from an IDLE cycle; cycle numbering starts at the start-sampling edge.
   task automatic run(input int abort_at, input int rst_at, input int limit,
                      output bit seen, output int cyc);
      start = 1'b1;
      cyc   = 0;
      seen  = 1'b0;
      while (!seen && cyc < limit) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         abort = (cyc == abort_at);
         rst_n = (cyc != rst_at);
         if (abort_at > 0 && cyc == abort_at + 1)
            check("abort_idle", {busy, done, cell_a, cell_b, cell_c}, 5'b00000);
         if (rst_at > 0 && cyc == rst_at + 1)
            check("midrun_reset", {busy, done, cell_a, cell_b, cell_c, pass, result,
                                   err_count, fail_valid, first_fail_idx}, '0);
         if (done) seen = 1'b1;
      end
      abort = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      bit seen;
      int cyc, d1, d2;
      repeat (3) @(negedge clk);
      check("reset_state", {busy, done, cell_a, cell_b, cell_c, result, err_count,
                            pass, fail_valid}, '0);
      rst_n = 1'b1;
      rst_nz = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      fault = 2'd0;
      run(0, 0, 200, seen, cyc);
      check("good_done_cycle", cyc, 33);
      check("good_result", result, 8'h14);
      check("good_status", {err_count, pass, fail_valid}, {4'd0, 1'b1, 1'b0});
      @(negedge clk);

      fault = 2'd1;
      run(0, 0, 200, seen, cyc);
      check("sa0_done_cycle", cyc, 33);
      check("sa0_result", result, 8'h00);
      check("sa0_status", {err_count, fail_valid, first_fail_idx, pass},
            {4'd2, 1'b1, 3'd2, 1'b0});
      @(negedge clk);

      fault = 2'd2;
      run(0, 0, 200, seen, cyc);
      check("sa1_result", result, 8'hFF);
      check("sa1_status", {err_count, fail_valid, first_fail_idx, pass},
            {4'd6, 1'b1, 3'd0, 1'b0});
      @(negedge clk);

      fault = 2'd0;
      run(10, 0, 60, seen, cyc);
      check("abort_no_done", seen, 0);
      check("abort_pass_low", pass, 0);
      run(0, 0, 200, seen, cyc);
      check("after_abort_result", {result, pass}, {8'h14, 1'b1});
      @(negedge clk);

      start = 1'b1;
      cyc = 0; d1 = 0; d2 = 0;
      while (d2 == 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            if (d1 == 0) d1 = cyc;
            else         d2 = cyc;
         end
      end
      start = 1'b0;
      check("held_first_done", d1, 33);
      check("held_spacing", d2 - d1, 34);
      repeat (2) @(negedge clk);

      run(0, 22, 60, seen, cyc);
      check("reset_no_done", seen, 0);
      @(negedge clk);

      start_z = 1'b1;
      cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge clk);
         cyc++;
         start_z = 1'b0;
         if (cyc == 2) check("z_abc_c2", {a_z, b_z, c_z}, 3'd0);
         if (cyc == 3) check("z_abc_c3", {a_z, b_z, c_z}, 3'd1);
         if (done_z) seen = 1'b1;
      end
      check("z_done_cycle", cyc, 17);
      check("z_result", {result_z, err_z, pass_z}, {8'h14, 4'd0, 1'b1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
